// File: rtl/draw_card_stack.sv
// draw_card_stack
//   Overlays up to N_SLOTS playing-card sprites on a video timing stream.
//   Each slot keeps a shadow copy of its placement (written by slot updates at
//   any time) and an active copy (used for drawing). Shadows are copied to
//   active on the first cycle of vertical blanking, so a frame is never drawn
//   with a half-updated card layout.
//
//   Pipeline: stage 1 registers the winning slot's ROM address and a hit flag,
//   ROM_LATENCY delay stages follow, and a final register composites the ROM
//   pixel over the background. All timing outputs are delayed identically
//   (ROM_LATENCY+2 cycles).
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   vcount_in..hblnk_in, rgb_in  upstream timing bus and background pixel
//   vcount_out..hblnk_out,rgb_out delayed timing bus and composited pixel
//   pixel_addr / rgb_pixel       card ROM address out / ROM data in
//   upd_valid, upd_slot, upd_xpos, upd_ypos, upd_card, upd_visible, upd_ready
//                                slot-update handshake (writes shadow only)
//
// Configuration
//   DRAW_CARD_STACK_TRANSP_EN    when defined, ROM pixels equal to TRANSP_KEY
//                                show the background instead.

module draw_card_stack #(
  parameter int          N_SLOTS     = 8,
  parameter int          CARD_WIDTH  = 55,
  parameter int          CARD_HEIGHT = 79,
  parameter int          ROM_LATENCY = 1,
  parameter int          ADDR_W      = 18,
  parameter logic [11:0] TRANSP_KEY  = 12'hF0F,
  localparam int         SLOT_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [10:0]       hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [11:0]       rgb_in,
  output logic [10:0]       vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [10:0]       hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [11:0]       rgb_out,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [11:0]       rgb_pixel,
  input  logic              upd_valid,
  input  logic [SLOT_W-1:0] upd_slot,
  input  logic [10:0]       upd_xpos,
  input  logic [10:0]       upd_ypos,
  input  logic [5:0]        upd_card,
  input  logic              upd_visible,
  output logic              upd_ready
);

  localparam int CARD_SIZE = CARD_WIDTH * CARD_HEIGHT;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
    logic        hit;
  } bus_t;

  // ---------------------------------------------------------------------------
  // Commit detection and update handshake
  // ---------------------------------------------------------------------------
  logic vblnk_prev_reg;
  logic commit;
  logic upd_accept;

  assign commit     = vblnk_in && !vblnk_prev_reg;
  // Combinational so it is already low while rst is held.
  assign upd_ready  = !rst && !commit;
  assign upd_accept = upd_valid && upd_ready;

  always_ff @(posedge clk) begin
    if (rst) vblnk_prev_reg <= 1'b0;
    else     vblnk_prev_reg <= vblnk_in;
  end

  // ---------------------------------------------------------------------------
  // Per-slot shadow/active storage and hit test
  // ---------------------------------------------------------------------------
  logic [N_SLOTS-1:0]             slot_hit;
  logic [N_SLOTS-1:0][ADDR_W-1:0] slot_addr;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      logic [10:0] sh_x_reg, sh_y_reg, act_x_reg, act_y_reg;
      logic [5:0]  sh_card_reg, act_card_reg;
      logic        sh_vis_reg, act_vis_reg;
      logic [11:0] h12, v12, x12, y12, x_end, y_end;
      logic        in_x, in_y;

      // Slot numbers that do not exist never match, so such updates are
      // accepted and dropped.
      always_ff @(posedge clk) begin
        if (rst) begin
          sh_x_reg     <= '0;
          sh_y_reg     <= '0;
          sh_card_reg  <= '0;
          sh_vis_reg   <= 1'b0;
          act_x_reg    <= '0;
          act_y_reg    <= '0;
          act_card_reg <= '0;
          act_vis_reg  <= 1'b0;
        end else begin
          if (upd_accept && upd_slot == SLOT_W'(gi)) begin
            sh_x_reg    <= upd_xpos;
            sh_y_reg    <= upd_ypos;
            sh_card_reg <= upd_card;
            sh_vis_reg  <= upd_visible;
          end
          if (commit) begin
            act_x_reg    <= sh_x_reg;
            act_y_reg    <= sh_y_reg;
            act_card_reg <= sh_card_reg;
            act_vis_reg  <= sh_vis_reg;
          end
        end
      end

      // 12-bit compare: a card near the right/bottom edge extends past 2047
      // instead of wrapping to the left/top of the screen.
      assign h12   = {1'b0, hcount_in};
      assign v12   = {1'b0, vcount_in};
      assign x12   = {1'b0, act_x_reg};
      assign y12   = {1'b0, act_y_reg};
      assign x_end = x12 + 12'(CARD_WIDTH - 1);
      assign y_end = y12 + 12'(CARD_HEIGHT - 1);
      assign in_x  = (h12 >= x12) && (h12 <= x_end);
      assign in_y  = (v12 >= y12) && (v12 <= y_end);

      assign slot_hit[gi]  = act_vis_reg && in_x && in_y;
      assign slot_addr[gi] = ADDR_W'(act_card_reg) * ADDR_W'(CARD_SIZE)
                           + ADDR_W'(v12 - y12) * ADDR_W'(CARD_WIDTH)
                           + ADDR_W'(h12 - x12);
    end
  endgenerate

  // Highest-index hit wins: later iterations overwrite earlier ones.
  logic              win_hit;
  logic [ADDR_W-1:0] win_addr;

  always_comb begin
    win_hit  = 1'b0;
    win_addr = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slot_hit[i]) begin
        win_hit  = 1'b1;
        win_addr = slot_addr[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 plus ROM_LATENCY delay stages
  // ---------------------------------------------------------------------------
  bus_t              pipe_reg [0:ROM_LATENCY];
  logic [ADDR_W-1:0] addr_reg;
  bus_t              stage_in;

  always_comb begin
    stage_in        = '0;
    stage_in.vcount = vcount_in;
    stage_in.vsync  = vsync_in;
    stage_in.vblnk  = vblnk_in;
    stage_in.hcount = hcount_in;
    stage_in.hsync  = hsync_in;
    stage_in.hblnk  = hblnk_in;
    stage_in.rgb    = rgb_in;
    stage_in.hit    = win_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      for (int i = 0; i <= ROM_LATENCY; i++) pipe_reg[i] <= '0;
    end else begin
      addr_reg    <= win_hit ? win_addr : '0;
      pipe_reg[0] <= stage_in;
      for (int i = 1; i <= ROM_LATENCY; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign pixel_addr = addr_reg;

  // ---------------------------------------------------------------------------
  // Compositing and output register
  // ---------------------------------------------------------------------------
  bus_t        tail;
  logic [11:0] rgb_next;

  assign tail = pipe_reg[ROM_LATENCY];

  always_comb begin
    rgb_next = tail.rgb;
    if (tail.vblnk || tail.hblnk) begin
      rgb_next = 12'h000;
    end else if (tail.hit) begin
`ifdef DRAW_CARD_STACK_TRANSP_EN
      rgb_next = (rgb_pixel == TRANSP_KEY) ? tail.rgb : rgb_pixel;
`else
      rgb_next = rgb_pixel;
`endif
    end
  end

`ifndef DRAW_CARD_STACK_TRANSP_EN
  logic unused_key;
  assign unused_key = ^TRANSP_KEY;
`endif

  bus_t        out_reg;
  logic [11:0] rgb_out_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg     <= '0;
      rgb_out_reg <= '0;
    end else begin
      out_reg     <= tail;
      rgb_out_reg <= rgb_next;
    end
  end

  logic unused_out_bits;
  assign unused_out_bits = ^{out_reg.rgb, out_reg.hit};

  assign vcount_out = out_reg.vcount;
  assign vsync_out  = out_reg.vsync;
  assign vblnk_out  = out_reg.vblnk;
  assign hcount_out = out_reg.hcount;
  assign hsync_out  = out_reg.hsync;
  assign hblnk_out  = out_reg.hblnk;
  assign rgb_out    = rgb_out_reg;

endmodule

// File: tb/tb_draw_card_stack.sv
// Directed bench for draw_card_stack (N_SLOTS=6, ROM_LATENCY=3).
// The ROM model returns addr[11:0] ^ 12'h5A5 after 3 cycles; expected
// addresses/pixels below are worked out by hand from that.
module tb_draw_card_stack;
  localparam int LAT = 3;
  localparam int NS  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;
  logic [17:0] pixel_addr;
  logic [11:0] rgb_pixel;
  logic        upd_valid;
  logic [2:0]  upd_slot;
  logic [10:0] upd_xpos, upd_ypos;
  logic [5:0]  upd_card;
  logic        upd_visible, upd_ready;

  int total = 0;
  int bad   = 0;

  draw_card_stack #(.N_SLOTS(NS), .ROM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .upd_valid(upd_valid), .upd_slot(upd_slot), .upd_xpos(upd_xpos),
    .upd_ypos(upd_ypos), .upd_card(upd_card), .upd_visible(upd_visible),
    .upd_ready(upd_ready)
  );

  always #5 clk = ~clk;

  // ROM model with LAT cycles of latency
  logic [11:0] rom_pipe [0:LAT-1];
  always @(posedge clk) begin
    rom_pipe[0] <= pixel_addr[11:0] ^ 12'h5A5;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rgb_pixel = rom_pipe[LAT-1];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    tick(LAT + 3);
    $display("probe (%0d,%0d) addr=%0d rgb=%h", h, v, pixel_addr, rgb_out);
  endtask

  task automatic upd(input int s, input int x, input int y, input int c, input logic vis);
    upd_slot = 3'(s); upd_xpos = 11'(x); upd_ypos = 11'(y);
    upd_card = 6'(c); upd_visible = vis; upd_valid = 1'b1;
    tick(1);
    upd_valid = 1'b0;
    $display("update slot=%0d x=%0d y=%0d card=%0d vis=%0b", s, x, y, c, vis);
  endtask

  task automatic commit();
    vblnk_in = 1'b0; tick(1);
    vblnk_in = 1'b1; tick(2);
    vblnk_in = 1'b0; tick(1);
    $display("vblank pulse");
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_valid = 1'b0; upd_slot = '0; upd_xpos = '0; upd_ypos = '0;
    upd_card = '0; upd_visible = 1'b0;
    hcount_in = 11'd5; vcount_in = 11'd5; hsync_in = 1'b1; vsync_in = 1'b1;
    vblnk_in = 1'b0; hblnk_in = 1'b0; rgb_in = 12'h123;
    tick(3);
    total++; if (rgb_out !== 12'h000) begin bad++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("FAIL reset_hsync: got %b want 0", hsync_out); end
    total++; if (vsync_out !== 1'b0) begin bad++; $display("FAIL reset_vsync: got %b want 0", vsync_out); end
    total++; if (hcount_out !== 11'd0) begin bad++; $display("FAIL reset_hcount: got %0d want 0", hcount_out); end
    total++; if (pixel_addr !== 18'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", pixel_addr); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", upd_ready); end
    rst = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    #1;
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", upd_ready); end
    probe(20, 30);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL no_cards_after_reset: got %h want 123", rgb_out); end
  endtask

  task automatic test_basic();
    upd(0, 20, 30, 0, 1'b1);
    probe(20, 30);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL basic_before_commit: got %h want 123", rgb_out); end
    commit();
    probe(20, 30);
    total++; if (pixel_addr !== 18'd0) begin bad++; $display("FAIL basic_addr_20_30: got %0d want 0", pixel_addr); end
    total++; if (rgb_out !== 12'h5A5) begin bad++; $display("FAIL basic_rgb_20_30: got %h want 5a5", rgb_out); end
    probe(74, 108);
    total++; if (pixel_addr !== 18'd4344) begin bad++; $display("FAIL basic_addr_74_108: got %0d want 4344", pixel_addr); end
    total++; if (rgb_out !== 12'h55D) begin bad++; $display("FAIL basic_rgb_74_108: got %h want 55d", rgb_out); end
    probe(75, 30);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL basic_right_edge: got %h want 123", rgb_out); end
    total++; if (pixel_addr !== 18'd0) begin bad++; $display("FAIL basic_miss_addr: got %0d want 0", pixel_addr); end
    probe(74, 109);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL basic_bottom_edge: got %h want 123", rgb_out); end
    probe(19, 30);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL basic_left_edge: got %h want 123", rgb_out); end
    hblnk_in = 1'b1;
    probe(20, 30);
    total++; if (rgb_out !== 12'h000) begin bad++; $display("FAIL basic_hblank_rgb: got %h want 000", rgb_out); end
    total++; if (hblnk_out !== 1'b1) begin bad++; $display("FAIL basic_hblank_out: got %b want 1", hblnk_out); end
    hblnk_in = 1'b0;
  endtask

  task automatic test_commit();
    upd(2, 200, 40, 1, 1'b1);
    probe(200, 40);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL commit_early: got %h want 123", rgb_out); end
    vblnk_in = 1'b0; tick(1);
    vblnk_in = 1'b1;
    upd_slot = 3'd3; upd_xpos = 11'd300; upd_ypos = 11'd40; upd_card = 6'd1;
    upd_visible = 1'b1; upd_valid = 1'b1;
    #1;
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL commit_ready_low: got %b want 0", upd_ready); end
    tick(1);
    upd_valid = 1'b0;
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL commit_ready_after: got %b want 1", upd_ready); end
    tick(1);
    vblnk_in = 1'b0;
    probe(200, 40);
    total++; if (pixel_addr !== 18'd4345) begin bad++; $display("FAIL commit_addr: got %0d want 4345", pixel_addr); end
    total++; if (rgb_out !== 12'h55C) begin bad++; $display("FAIL commit_rgb: got %h want 55c", rgb_out); end
    probe(300, 40);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL commit_cycle_update_dropped: got %h want 123", rgb_out); end
  endtask

  task automatic test_overlap();
    upd(1, 90, 90, 2, 1'b1);
    upd(5, 95, 95, 3, 1'b1);
    upd(7, 400, 40, 0, 1'b1);
    commit();
    probe(100, 100);
    total++; if (pixel_addr !== 18'd13315) begin bad++; $display("FAIL overlap_addr: got %0d want 13315", pixel_addr); end
    total++; if (rgb_out !== 12'h1A6) begin bad++; $display("FAIL overlap_rgb: got %h want 1a6", rgb_out); end
    probe(91, 91);
    total++; if (pixel_addr !== 18'd8746) begin bad++; $display("FAIL lower_slot_addr: got %0d want 8746", pixel_addr); end
    total++; if (rgb_out !== 12'h78F) begin bad++; $display("FAIL lower_slot_rgb: got %h want 78f", rgb_out); end
    probe(400, 40);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL bad_slot_discarded: got %h want 123", rgb_out); end
  endtask

  task automatic test_transp();
    logic [11:0] want;
`ifdef DRAW_CARD_STACK_TRANSP_EN
    want = 12'h123;
`else
    want = 12'hF0F;
`endif
    probe(55, 79);
    total++; if (pixel_addr !== 18'd2730) begin bad++; $display("FAIL transp_addr: got %0d want 2730", pixel_addr); end
    total++; if (rgb_out !== want) begin bad++; $display("FAIL transp_rgb: got %h want %h", rgb_out, want); end
  endtask

  task automatic test_latency();
    logic        hs [1:7];
    logic [11:0] rg [1:7];
    logic [10:0] hc [1:7];
    probe(19, 30);
    hcount_in = 11'd20; hsync_in = 1'b1;
    tick(1);
    hs[1] = hsync_out; rg[1] = rgb_out; hc[1] = hcount_out;
    hcount_in = 11'd19; hsync_in = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      tick(1);
      hs[k] = hsync_out; rg[k] = rgb_out; hc[k] = hcount_out;
    end
    $display("latency trace hsync=%b%b%b%b%b%b%b", hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]);
    for (int k = 1; k <= 7; k++) begin
      total++;
      if (hs[k] !== (k == 5)) begin bad++; $display("FAIL latency_hsync_t%0d: got %b want %b", k, hs[k], (k == 5)); end
    end
    for (int k = 4; k <= 6; k++) begin
      total++;
      if (rg[k] !== ((k == 5) ? 12'h5A5 : 12'h123)) begin
        bad++; $display("FAIL latency_rgb_t%0d: got %h want %h", k, rg[k], ((k == 5) ? 12'h5A5 : 12'h123));
      end
    end
    total++; if (hc[5] !== 11'd20) begin bad++; $display("FAIL latency_hcount: got %0d want 20", hc[5]); end
  endtask

  task automatic test_offscreen();
    upd(4, 2000, 10, 5, 1'b1);
    commit();
    probe(0, 10);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL offscreen_x0: got %h want 123", rgb_out); end
    probe(6, 10);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL offscreen_nowrap: got %h want 123", rgb_out); end
    total++; if (pixel_addr !== 18'd0) begin bad++; $display("FAIL offscreen_addr: got %0d want 0", pixel_addr); end
  endtask

  task automatic test_reset_midline();
    hsync_in = 1'b1;
    probe(20, 30);
    total++; if (rgb_out !== 12'h5A5) begin bad++; $display("FAIL midline_pre: got %h want 5a5", rgb_out); end
    rst = 1'b1;
    tick(1);
    total++; if (rgb_out !== 12'h000) begin bad++; $display("FAIL midline_rgb: got %h want 000", rgb_out); end
    total++; if (pixel_addr !== 18'd0) begin bad++; $display("FAIL midline_addr: got %0d want 0", pixel_addr); end
    total++; if (hcount_out !== 11'd0) begin bad++; $display("FAIL midline_hcount: got %0d want 0", hcount_out); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("FAIL midline_hsync: got %b want 0", hsync_out); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL midline_ready: got %b want 0", upd_ready); end
    rst = 1'b0; hsync_in = 1'b0;
    probe(20, 30);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL midline_blank: got %h want 123", rgb_out); end
    commit();
    probe(20, 30);
    total++; if (rgb_out !== 12'h123) begin bad++; $display("FAIL midline_blank_commit: got %h want 123", rgb_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_commit();
    test_overlap();
    test_transp();
    test_latency();
    test_offscreen();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/draw_card_stack.md
DRAW_CARD_STACK -- requirements
Module: draw_card_stack

Interface
REQ-001 Parameter N_SLOTS, default 8: number of independently placed card slots (1..16).
REQ-002 Parameter CARD_WIDTH, default 55: card bitmap width in pixels.
REQ-003 Parameter CARD_HEIGHT, default 79: card bitmap height in pixels.
REQ-004 Parameter ROM_LATENCY, default 1: cycles from pixel_addr to rgb_pixel (0..4).
REQ-005 Parameter ADDR_W, default 18: pixel_addr width; holds 52*CARD_WIDTH*CARD_HEIGHT.
REQ-006 Parameter TRANSP_KEY, default 12'hF0F: bitmap colour treated as transparent.
REQ-007 Port clk, input, 1: posedge clock, the only clock.
REQ-008 Port rst, input, 1: synchronous, active-high reset.
REQ-009 Ports vcount_in/hcount_in (11), vsync_in/vblnk_in/hsync_in/hblnk_in (1), rgb_in (12), input: upstream timing bus and background.
REQ-010 Ports vcount_out/hcount_out (11), vsync_out/vblnk_out/hsync_out/hblnk_out (1), rgb_out (12), output: delayed timing bus and composited pixel.
REQ-011 Port pixel_addr, output, ADDR_W: card ROM address.
REQ-012 Port rgb_pixel, input, 12: ROM data.
REQ-013 Ports upd_valid (1), upd_slot ($clog2(N_SLOTS)), upd_xpos (11), upd_ypos (11), upd_card (6, 0..51), upd_visible (1), input: slot-update request.
REQ-014 Port upd_ready, output, 1: update accepted when upd_valid && upd_ready.

Function
REQ-015 Each slot SHALL hold a shadow and an active copy of {xpos, ypos, card, visible}.
REQ-016 An accepted update SHALL write only the shadow entry of upd_slot.
REQ-017 On the first cycle vblnk_in is high after being low (commit cycle), all shadow entries SHALL copy to active; upd_ready SHALL be low that cycle.
REQ-018 upd_ready SHALL be high in every other non-reset cycle; updates never stall otherwise.
REQ-019 Slot s SHALL hit when active visible, xpos<=hcount_in<=xpos+CARD_WIDTH-1, ypos<=vcount_in<=ypos+CARD_HEIGHT-1, compared at 12 bits (no wrap).
REQ-020 With several hits, the highest slot index SHALL win (drawn on top).
REQ-021 Stage 1: pixel_addr SHALL register card*CARD_WIDTH*CARD_HEIGHT+(vcount_in-ypos)*CARD_WIDTH+(hcount_in-xpos) of the winning slot, else 0; a hit flag SHALL be pipelined alongside.
REQ-022 rgb_out SHALL be registered ROM_LATENCY+2 cycles after the inputs it belongs to; all timing outputs SHALL be delayed identically.
REQ-023 Output pixel: 0 if delayed vblnk or hblnk high; else rgb_pixel if delayed hit flag set (subject to REQ-029); else delayed rgb_in.
REQ-024 Off-screen card portions SHALL be clipped silently; no error signalled.
REQ-025 upd_slot >= N_SLOTS SHALL be accepted and discarded.

Reset
REQ-026 During rst all outputs SHALL be 0, upd_ready 0, all delay stages cleared.
REQ-027 rst SHALL clear every shadow and active entry to visible=0, xpos=ypos=0, card=0.
REQ-028 Reset mid-frame SHALL blank cards until the first commit after an update.

Configuration
REQ-029 Macro DRAW_CARD_STACK_TRANSP_EN defined: a hit whose rgb_pixel equals TRANSP_KEY SHALL show delayed rgb_in; undefined: rgb_pixel always shown, TRANSP_KEY unused.

Verification
REQ-030 Reset, then slot 0 {x=20,y=30,card=0,visible=1}, one vblank -> pixel (20,30) addr 0, (74,108) addr 4344, (75,30) shows rgb_in.
REQ-031 Update slot 2 mid-frame -> no change until next vblnk rising edge; upd_ready low exactly in that commit cycle.
REQ-032 Slots 1 and 5 overlap at (100,100) -> slot 5 address/pixel shown.
REQ-033 ROM_LATENCY=3, hsync_in pulse at cycle t -> hsync_out pulse at t+5, aligned with rgb_out.
REQ-034 TRANSP_EN defined, rgb_pixel=12'hF0F, rgb_in=12'h123 -> rgb_out 12'h123; undefined -> 12'hF0F.
REQ-035 Slot at x=2000 (off-screen) -> no hit anywhere; rst asserted mid-line -> all outputs 0 next cycle.
